cp0_int_ctrl: RTL

- Interrupt controller that sits beside the CP0 in the writeback stage.
- Samples six external hardware interrupt lines and the core timer interrupt, then produces the Cause.IP[7:2] hardware bits.
- Qualifies pending interrupts with Status.IE, Status.EXL and Status.IM.
- Sequences one interrupt at a time into the pipeline with a req/ack handshake to decode. It holds off further requests until the tagged instruction commits its exception in writeback, or until the request is cancelled.

---
 rtl/cp0_int_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cp0_int_ctrl.sv
// Interrupt sequencer beside CP0: samples hw/timer lines into Cause.IP[7:2] and hands one
// qualified interrupt at a time to decode. Define CP0_INT_SYNC_EN to double-flop hw_int first.
module cp0_int_ctrl #(
  parameter int TIMEOUT_W = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] hw_int,
  input  logic       time_int,
  input  logic       status_ie,
  input  logic       status_exl,
  input  logic [7:0] status_im,
  input  logic [1:0] cause_ip_sw,
  input  logic       int_ack,
  input  logic       ws_ex,
  input  logic       eret,
  output logic [5:0] cause_ip_hw,
  output logic       int_req,
  output logic       int_pending
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    INFLIGHT = 2'd2
  } state_t;

  state_t               state_r;
  logic [5:0]           ip_r;
  logic [5:0]           hw_s;
  logic [TIMEOUT_W-1:0] cnt_r;
  logic                 int_req_r;
  logic                 commit_s;

`ifdef CP0_INT_SYNC_EN
  logic [5:0] sync1_r;
  logic [5:0] sync2_r;

  // Two-flop synchronizer for the asynchronous external lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 6'd0;
      sync2_r <= 6'd0;
    end else begin
      sync1_r <= hw_int;
      sync2_r <= sync1_r;
    end
  end

  assign hw_s = sync2_r;
`else
  assign hw_s = hw_int;
`endif

  // Level-sensitive sampling; the timer shares IP7 with hw line 5.
  always_ff @(posedge clk) begin
    if (reset) begin
      ip_r <= 6'd0;
    end else begin
      ip_r <= {hw_s[5] | time_int, hw_s[4:0]};
    end
  end

  assign cause_ip_hw = ip_r;
  assign int_pending = status_ie & ~status_exl & (|({ip_r, cause_ip_sw} & status_im));
  assign commit_s    = ws_ex | eret;

  // Request sequencer; the watchdog recovers if the tagged instruction is flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      int_req_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (int_pending) begin
            state_r   <= REQ;
            int_req_r <= 1'b1;
          end else begin
            state_r   <= IDLE;
            int_req_r <= 1'b0;
          end
        end
        REQ: begin
          cnt_r <= '0;
          if (int_ack) begin
            state_r   <= INFLIGHT;
            int_req_r <= 1'b0;
          end else if (!int_pending) begin
            state_r   <= IDLE;
            int_req_r <= 1'b0;
          end else begin
            state_r   <= REQ;
            int_req_r <= 1'b1;
          end
        end
        INFLIGHT: begin
          int_req_r <= 1'b0;
          if (commit_s || (cnt_r == TIMEOUT_W'(TIMEOUT))) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else begin
            state_r <= INFLIGHT;
            cnt_r   <= cnt_r + TIMEOUT_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= '0;
          int_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign int_req = int_req_r;

endmodule
